cim_row_bank: RTL and testbench

CIM_ROW_BANK -- requirements
Module: cim_row_bank

---
 rtl/cim_pkg.sv | 19 +
 rtl/cim_row_bank_if.sv | 50 +++++
 rtl/cim_bit_seq.sv | 129 ++++++++++++
 rtl/cim_row_bank.sv | 123 ++++++++++++
 tb/tb_cim_row_bank.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cim_pkg.sv
// Shared types and defaults for the compute-in-memory row bank.
// Optional feature macro: CIM_ROW_BANK_DUAL_OPERAND_EN (second serial source operand).
package cim_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_ROWS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  // Row address width, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/cim_row_bank_if.sv
// Parallel and bit-serial port bundle of cim_row_bank.
// CIM_ROW_BANK_DUAL_OPERAND_EN adds ser_src_b / to_adder_b.
interface cim_row_bank_if #(
  parameter int unsigned WIDTH = cim_pkg::DEF_WIDTH,
  parameter int unsigned ROWS  = cim_pkg::DEF_ROWS
);
  localparam int unsigned AW = cim_pkg::addr_w(ROWS);

  logic             clr;
  logic             wr_en;
  logic [AW-1:0]    wr_row;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_row;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             ser_start;
  logic [AW-1:0]    ser_src;
  logic [AW-1:0]    ser_dst;
  logic             ser_busy;
  logic             ser_done;
  logic             to_adder;
  logic             to_adder_valid;
  logic             from_adder;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
  logic [AW-1:0]    ser_src_b;
  logic             to_adder_b;
`endif

  modport slave (
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
    input  ser_src_b,
    output to_adder_b,
`endif
    input  clr, wr_en, wr_row, wr_data, rd_en, rd_row,
    input  ser_start, ser_src, ser_dst, from_adder,
    output rd_data, rd_valid, ser_busy, ser_done, to_adder, to_adder_valid
  );

  modport master (
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
    output ser_src_b,
    input  to_adder_b,
`endif
    output clr, wr_en, wr_row, wr_data, rd_en, rd_row,
    output ser_start, ser_src, ser_dst, from_adder,
    input  rd_data, rd_valid, ser_busy, ser_done, to_adder, to_adder_valid
  );

endinterface

// File: rtl/cim_bit_seq.sv
// Bit-serial pass sequencer: FSM, bit counter, operand/destination latches.
// CIM_ROW_BANK_DUAL_OPERAND_EN adds the second source latch.
module cim_bit_seq
  import cim_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned AW    = 3,
  localparam int unsigned KW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          start_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
  input  logic [AW-1:0] src_b_i,
  output logic [AW-1:0] fetch_row_b_c,
`endif
  output logic          busy_o,
  output logic          done_o,
  output logic          shift_o,
  output logic [KW-1:0] k_o,
  output logic [AW-1:0] dst_o,
  output logic          fetch_en_c,
  output logic [AW-1:0] fetch_row_c,
  output logic [KW-1:0] fetch_bit_c
);

  seq_state_e    state_q;
  logic [KW-1:0] k_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic          busy_q;
  logic          done_q;
  logic          shift_q;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
  logic [AW-1:0] src_b_q;
`endif
  logic          last_bit;

  assign last_bit = (k_q == KW'(WIDTH - 1));

  // Source bit to present in the next cycle, prefetched so to_adder is a flop.
  always_comb begin
    fetch_en_c  = 1'b0;
    fetch_row_c = src_q;
    fetch_bit_c = KW'(k_q + KW'(1));
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
    fetch_row_b_c = src_b_q;
`endif
    if (state_q == ST_IDLE) begin
      fetch_en_c  = start_i;
      fetch_row_c = src_i;
      fetch_bit_c = '0;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
      fetch_row_b_c = src_b_i;
`endif
    end else if (state_q == ST_SHIFT) begin
      fetch_en_c = !last_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= 1'b0;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
      src_b_q <= '0;
`endif
    end else if (clr) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_SHIFT;
            src_q   <= src_i;
            dst_q   <= dst_i;
            k_q     <= '0;
            busy_q  <= 1'b1;
            shift_q <= 1'b1;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
            src_b_q <= src_b_i;
`endif
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            state_q <= ST_DONE;
            k_q     <= '0;
            shift_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q <= KW'(k_q + KW'(1));
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          k_q     <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          shift_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign shift_o = shift_q;
  assign k_o     = k_q;
  assign dst_o   = dst_q;

endmodule

// File: rtl/cim_row_bank.sv
// Row storage with parallel read/write and a bit-serial pass through an external adder.
// CIM_ROW_BANK_DUAL_OPERAND_EN streams a second source row on to_adder_b.
module cim_row_bank
  import cim_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ROWS  = DEF_ROWS
) (
  input logic           clk,
  input logic           rst,
  cim_row_bank_if.slave bus
);

  localparam int unsigned AW = addr_w(ROWS);
  localparam int unsigned KW = $clog2(WIDTH);

  logic [WIDTH-1:0] mem_q [ROWS];
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             to_adder_q;

  logic             start_ok;
  logic             busy;
  logic             done;
  logic             shift;
  logic [KW-1:0]    k;
  logic [AW-1:0]    dst;
  logic             fetch_en;
  logic [AW-1:0]    fetch_row;
  logic [KW-1:0]    fetch_bit;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
  logic [AW-1:0]    fetch_row_b;
  logic             to_adder_b_q;
`endif

  function automatic logic in_range(input logic [AW-1:0] row);
    return 32'(row) < ROWS;
  endfunction

  // A pass only starts when every addressed row exists.
  always_comb begin
    start_ok = bus.ser_start && in_range(bus.ser_src) && in_range(bus.ser_dst);
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
    start_ok = start_ok && in_range(bus.ser_src_b);
`endif
  end

  cim_bit_seq #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .clr           (bus.clr),
    .start_i       (start_ok),
    .src_i         (bus.ser_src),
    .dst_i         (bus.ser_dst),
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
    .src_b_i       (bus.ser_src_b),
    .fetch_row_b_c (fetch_row_b),
`endif
    .busy_o        (busy),
    .done_o        (done),
    .shift_o       (shift),
    .k_o           (k),
    .dst_o         (dst),
    .fetch_en_c    (fetch_en),
    .fetch_row_c   (fetch_row),
    .fetch_bit_c   (fetch_bit)
  );

  // Storage: serial write-back owns the array for the whole pass.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      for (int i = 0; i < int'(ROWS); i++) mem_q[i] <= '0;
    end else if (shift) begin
      mem_q[dst][k] <= bus.from_adder;
    end else if (bus.wr_en && !busy && in_range(bus.wr_row)) begin
      mem_q[bus.wr_row] <= bus.wr_data;
    end
  end

  // Parallel read port, serviced even during a pass; clr leaves rd_data alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (bus.clr) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= in_range(bus.rd_row) ? mem_q[bus.rd_row] : '0;
      end
    end
  end

  // Source bit(s) registered one cycle ahead from pre-edge contents.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      to_adder_q <= 1'b0;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
      to_adder_b_q <= 1'b0;
`endif
    end else begin
      to_adder_q <= fetch_en ? mem_q[fetch_row][fetch_bit] : 1'b0;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
      to_adder_b_q <= fetch_en ? mem_q[fetch_row_b][fetch_bit] : 1'b0;
`endif
    end
  end

  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.ser_busy       = busy;
  assign bus.ser_done       = done;
  assign bus.to_adder       = to_adder_q;
  assign bus.to_adder_valid = shift;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
  assign bus.to_adder_b     = to_adder_b_q;
`endif

endmodule

// File: tb/tb_cim_row_bank.sv
// Directed bench for cim_row_bank: an 8x8 instance plus a 6-row instance for out-of-range rows.
module tb_cim_row_bank;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cim_row_bank_if #(.WIDTH(8), .ROWS(8)) bus  ();
  cim_row_bank_if #(.WIDTH(8), .ROWS(6)) bus6 ();

  cim_row_bank #(.WIDTH(8), .ROWS(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  cim_row_bank #(.WIDTH(8), .ROWS(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  // External bit-serial "adder": inverts the streamed bit.
  assign bus.from_adder  = ~bus.to_adder;
  assign bus6.from_adder = ~bus6.to_adder;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr = 1'b0;  bus.wr_en = 1'b0;  bus.wr_row = '0;  bus.wr_data = '0;
    bus.rd_en = 1'b0;  bus.rd_row = '0;  bus.ser_start = 1'b0;
    bus.ser_src = '0;  bus.ser_dst = '0;
    bus6.clr = 1'b0; bus6.wr_en = 1'b0; bus6.wr_row = '0; bus6.wr_data = '0;
    bus6.rd_en = 1'b0; bus6.rd_row = '0; bus6.ser_start = 1'b0;
    bus6.ser_src = '0; bus6.ser_dst = '0;
`ifdef CIM_ROW_BANK_DUAL_OPERAND_EN
    bus.ser_src_b = '0;
    bus6.ser_src_b = '0;
`endif
  endtask

  task automatic wr(input logic [2:0] row, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_row = row; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] row, input logic [7:0] exp);
    bus.rd_en = 1'b1; bus.rd_row = row;
    tick();
    bus.rd_en = 1'b0;
    check(tag, 32'(bus.rd_data), 32'(exp));
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
  endtask

  task automatic wr6(input logic [2:0] row, input logic [7:0] d);
    bus6.wr_en = 1'b1; bus6.wr_row = row; bus6.wr_data = d;
    tick();
    bus6.wr_en = 1'b0;
  endtask

  task automatic rd6_check(input string tag, input logic [2:0] row, input logic [7:0] exp);
    bus6.rd_en = 1'b1; bus6.rd_row = row;
    tick();
    bus6.rd_en = 1'b0;
    check(tag, 32'(bus6.rd_data), 32'(exp));
    check({tag, "_valid"}, 32'(bus6.rd_valid), 32'd1);
  endtask

  task automatic start(input logic [2:0] src, input logic [2:0] dst);
    bus.ser_start = 1'b1; bus.ser_src = src; bus.ser_dst = dst;
    tick();
    bus.ser_start = 1'b0;
  endtask

  // Observes a pass starting in cycle 1 after start(); optionally disturbs it.
  task automatic watch_pass(input string tag, input logic [7:0] src_val, input bit disturb);
    int busy_n = 0;
    int done_n = 0;
    int done_at = 0;
    int valid_n = 0;
    logic [2:0] bi = '0;
    for (int c = 1; c <= 14; c++) begin
      if (bus.ser_busy) busy_n++;
      if (bus.ser_done) begin
        done_n++;
        done_at = c;
      end
      if (bus.to_adder_valid) begin
        check({tag, "_bit"}, 32'(bus.to_adder), 32'(src_val[bi]));
        bi = bi + 3'd1;
        valid_n++;
      end
      if (disturb && c == 5) begin
        check({tag, "_busy_rd"}, 32'(bus.rd_data), 32'hC3);
        check({tag, "_busy_rdv"}, 32'(bus.rd_valid), 32'd1);
      end
      if (disturb && c == 3) begin
        bus.wr_en = 1'b1; bus.wr_row = 3'd2; bus.wr_data = 8'hFF;
        bus.ser_start = 1'b1; bus.ser_src = 3'd3; bus.ser_dst = 3'd2;
      end else if (disturb && c == 4) begin
        bus.wr_en = 1'b0; bus.ser_start = 1'b0;
        bus.rd_en = 1'b1; bus.rd_row = 3'd3;
      end else begin
        bus.rd_en = 1'b0;
      end
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
    check({tag, "_done_count"}, 32'(done_n), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'd9);
    check({tag, "_valid_cycles"}, 32'(valid_n), 32'd8);
  endtask

  initial begin
    int done_seen;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_rd_data", 32'(bus.rd_data), 32'h0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_busy", 32'(bus.ser_busy), 32'd0);
    check("rst_done", 32'(bus.ser_done), 32'd0);
    check("rst_to_adder", 32'(bus.to_adder), 32'd0);
    check("rst_to_adder_valid", 32'(bus.to_adder_valid), 32'd0);

    // Parallel write then read, latency one
    wr(3'd3, 8'hA5);
    rd_check("rd_row3", 3'd3, 8'hA5);
    tick();
    check("rd_valid_drop", 32'(bus.rd_valid), 32'd0);
    check("rd_data_hold", 32'(bus.rd_data), 32'hA5);

    // Same-cycle read of a row being written returns old contents
    bus.wr_en = 1'b1; bus.wr_row = 3'd4; bus.wr_data = 8'h3C;
    bus.rd_en = 1'b1; bus.rd_row = 3'd4;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("rd_old_data", 32'(bus.rd_data), 32'h00);
    rd_check("rd_row4_new", 3'd4, 8'h3C);

    // Serial pass src=3 dst=5
    start(3'd3, 3'd5);
    watch_pass("pass35", 8'hA5, 1'b0);
    rd_check("pass35_dst", 3'd5, 8'h5A);
    rd_check("pass35_src", 3'd3, 8'hA5);

    // In-place pass
    start(3'd3, 3'd3);
    watch_pass("inplace", 8'hA5, 1'b0);
    rd_check("inplace_row3", 3'd3, 8'h5A);

    // clr at k=4 aborts the pass and wipes storage
    start(3'd3, 3'd6);
    for (int i = 0; i < 4; i++) tick();
    check("clr_pre_valid", 32'(bus.to_adder_valid), 32'd1);
    check("clr_pre_bit4", 32'(bus.to_adder), 32'd1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_busy", 32'(bus.ser_busy), 32'd0);
    check("clr_valid", 32'(bus.to_adder_valid), 32'd0);
    check("clr_rd_data_kept", 32'(bus.rd_data), 32'h5A);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.ser_done) done_seen++;
      tick();
    end
    check("clr_no_done", 32'(done_seen), 32'd0);
    bus.clr = 1'b1; bus.ser_start = 1'b1; bus.ser_src = 3'd0; bus.ser_dst = 3'd1;
    tick();
    bus.clr = 1'b0; bus.ser_start = 1'b0;
    check("clr_start_ignored", 32'(bus.ser_busy), 32'd0);
    rd_check("clr_row3", 3'd3, 8'h00);
    rd_check("clr_row6", 3'd6, 8'h00);

    // Busy pass ignores wr_en and a second start, still serves reads
    wr(3'd3, 8'hC3);
    start(3'd3, 3'd4);
    watch_pass("busy", 8'hC3, 1'b1);
    rd_check("busy_row2", 3'd2, 8'h00);
    rd_check("busy_row4", 3'd4, 8'h3C);

    // Out-of-range rows on the 6-row bank
    wr6(3'd5, 8'h55);
    wr6(3'd7, 8'h77);
    rd6_check("oor_row5", 3'd5, 8'h55);
    rd6_check("oor_row7", 3'd7, 8'h00);
    rd6_check("oor_row1", 3'd1, 8'h00);
    bus6.ser_start = 1'b1; bus6.ser_src = 3'd7; bus6.ser_dst = 3'd1;
    tick();
    check("oor_src_start", 32'(bus6.ser_busy), 32'd0);
    bus6.ser_src = 3'd5; bus6.ser_dst = 3'd6;
    tick();
    bus6.ser_start = 1'b0;
    check("oor_dst_start", 32'(bus6.ser_busy), 32'd0);

    // rst mid-pass aborts and zeroes the partial destination
    start(3'd3, 3'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(bus.ser_busy), 32'd0);
    check("midrst_done", 32'(bus.ser_done), 32'd0);
    check("midrst_valid", 32'(bus.to_adder_valid), 32'd0);
    check("midrst_rd_data", 32'(bus.rd_data), 32'h0);
    rd_check("midrst_row1", 3'd1, 8'h00);
    rd_check("midrst_row3", 3'd3, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
